// File: rtl/dc_pkg.sv
// Shared definitions for the delay-commutator chain: stage delay schedule,
// end-to-end latency and the commutator phase encoding.
package dc_pkg;

    localparam int MAX_STAGES = 8;

    // PH_LOAD: lane-0 input enters the lane-0 delay; PH_SWAP: lanes cross over.
    typedef enum logic {
        PH_LOAD = 1'b0,
        PH_SWAP = 1'b1
    } phase_e;

    function automatic int stage_delay(input int s, input int stages, input int descending);
        if (descending != 0) begin
            return 1 << (stages - 1 - s);
        end
        return 1 << s;
    endfunction

    function automatic int total_latency(input int stages);
        return (1 << stages) - 1 + stages;
    endfunction

endpackage

// File: rtl/dc_stage.sv
// One 2-lane delay-commutator stage: lane-1 delay, phase switch, lane-0 delay,
// all advancing only on accepted pairs.
module dc_stage
    import dc_pkg::*;
#(
    parameter int DELAY      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic                  out_valid,
    output logic                  primed
);

    localparam int            CW       = $clog2(2 * DELAY);
    localparam logic [CW-1:0] LAST     = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] HALF     = CW'(DELAY);
    localparam logic [CW-1:0] PRIME_AT = CW'(DELAY - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  primed_q, primed_d;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] y0_q, y0_d;
    logic [DATA_WIDTH-1:0] y1_q, y1_d;
    logic [DATA_WIDTH-1:0] line0_q [DELAY];
    logic [DATA_WIDTH-1:0] line1_q [DELAY];
    logic [DATA_WIDTH-1:0] mid0, mid1, d1;
    phase_e                phase;
    logic                  accept;

    assign accept = in_valid && !reset && !flush;

    always_comb begin
        phase    = (cnt_q >= HALF) ? PH_SWAP : PH_LOAD;
        d1       = line1_q[DELAY-1];
        mid0     = (phase == PH_SWAP) ? d1 : x0;
        mid1     = (phase == PH_SWAP) ? x0 : d1;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        vld_d    = 1'b0;
        y0_d     = y0_q;
        y1_d     = y1_q;
        if (in_valid) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == PRIME_AT) begin
                primed_d = 1'b1;
            end
            // Validity reflects priming state before this accept.
            vld_d = primed_q;
            y0_d  = line0_q[DELAY-1];
            y1_d  = mid1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            vld_q    <= 1'b0;
            y0_q     <= '0;
            y1_q     <= '0;
        end else if (flush) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            vld_q    <= vld_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
        end
    end

    // Delay lines hold payload only and are never cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = DELAY - 1; i > 0; i--) begin
                line0_q[i] <= line0_q[i-1];
                line1_q[i] <= line1_q[i-1];
            end
            line0_q[0] <= mid0;
            line1_q[0] <= x1;
        end
    end

    assign y0        = y0_q;
    assign y1        = y1_q;
    assign out_valid = vld_q;
    assign primed    = primed_q;

endmodule

// File: rtl/dc_chain_n.sv
// Cascade of STAGES delay-commutator stages implementing MDC radix-2
// inter-stage reordering, with descending or ascending delay schedule.
module dc_chain_n
    import dc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 2,
    parameter int DESCENDING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic                  out_valid,
    output logic [STAGES-1:0]     stage_primed
);

    logic [STAGES:0][DATA_WIDTH-1:0] lane0;
    logic [STAGES:0][DATA_WIDTH-1:0] lane1;
    logic [STAGES:0]                 vld;

    assign lane0[0] = x0;
    assign lane1[0] = x1;
    assign vld[0]   = in_valid;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        dc_stage #(
            .DELAY      (stage_delay(s, STAGES, DESCENDING)),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (vld[s]),
            .x0        (lane0[s]),
            .x1        (lane1[s]),
            .y0        (lane0[s+1]),
            .y1        (lane1[s+1]),
            .out_valid (vld[s+1]),
            .primed    (stage_primed[s])
        );
    end

    assign y0        = lane0[STAGES];
    assign y1        = lane1[STAGES];
    assign out_valid = vld[STAGES];

endmodule

// File: doc/dc_chain_n.md
Name: dc_chain_n

Overview:
- Parametrised cascade of 2-lane delay-commutator stages. Performs the inter-stage data reordering of a 2-parallel MDC radix-2 FFT for any power-of-two block length.
- Generalises the fixed two-stage chain (delays 2,1) to STAGES stages with selectable delay direction.
- Adds input-valid gating with stall tolerance, a synchronous flush, and per-stage priming.
- Sits between butterfly columns. Its output feeds the next butterfly/twiddle stage.

Parameters:
- DATA_WIDTH, 16: bits per lane sample (opaque payload; complex packing is the caller's concern).
- STAGES, 2: number of commutator stages, 1..8.
- DESCENDING, 1: 1 gives stage delays 2^(STAGES-1) down to 1; 0 gives delays 1 up to 2^(STAGES-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  x0/x1 carry a sample pair this cycle
- flush  in  1  synchronous clear of counters and priming, datapath contents don't-care
- x0  in  DATA_WIDTH  lane 0 input
- x1  in  DATA_WIDTH  lane 1 input
- y0  out  DATA_WIDTH  lane 0 output, registered
- y1  out  DATA_WIDTH  lane 1 output, registered
- out_valid  out  1  y0/y1 valid this cycle, registered
- stage_primed  out  STAGES  per-stage primed flags (debug/status)

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, on port reset. Reset forces y0=y1=0, out_valid=0, stage_primed=0, and all stage counters to 0. Delay-line contents are not reset.
- flush has the same effect as reset on counters, primed flags and out_valid. y0/y1 hold. flush overrides in_valid in the same cycle (that sample is dropped).
- Stage s has delay D_s and a modulo-2*D_s counter of accepted pairs. A pair is accepted on each cycle where the stage's input valid is high.
- Stage s input valid is in_valid for s=0, else the out_valid of stage s-1.
- Stage datapath (per block of 2D accepted pairs, A=x0[0..D-1], B=x1[0..D-1], C=x0[D..2D-1], E=x1[D..2D-1]):
  - Output pair sequence is (A[j],C[j]) for j=0..D-1, then (B[j],E[j]).
  - Output j is produced on the cycle input j+D is accepted and is registered, so it appears one cycle later with the stage valid high.
- Priming: a stage's primed flag sets after D accepted pairs and stays set until reset/flush. Stage valid out = registered (accept AND primed-before-this-accept).
- Stalls: all delay lines and counters advance only on accept. in_valid low freezes the stage, so gaps in input produce equal gaps in output with no data loss or duplication.
- Continuous-input latency from first in_valid to first out_valid is (2^STAGES - 1) + STAGES cycles (5 for defaults).
- Tail: the last D_s pairs per stage remain buffered until further input arrives. Callers drain by streaming the next block or dummy pairs.
- Counter wrap from 2D-1 to 0 switches the commutator back to the A/C phase.
- Simultaneous reset and flush: reset wins (identical effect).
- Reset or flush mid-block discards the partial block. The next accepted pair is block index 0.
- STAGES=1, D=1: 2x2 transpose of consecutive pairs.

Decomposition:
- Shared package dc_pkg holds:
  - function stage_delay(s, STAGES, DESCENDING) returning a power of two;
  - constant function total_latency(STAGES);
  - localparam MAX_STAGES=8.
- One sub-module, dc_stage: parameters DELAY, DATA_WIDTH; ports clk, reset, flush, in_valid, x0, x1, y0, y1, out_valid, primed.
- The top level is a generate loop over dc_stage.

Test Plan:
- Defaults, continuous in_valid, x0=k, x1=16+k, k=0..11 -> first out_valid at cycle 5. y pairs in order: (0,1),(2,3),(16,17),(18,19),(4,5),(6,7),(20,21),(22,23).
- Same stream with in_valid low for 3 cycles after k=2 and after k=5 -> identical output pair sequence. out_valid has matching gaps, and no pair is repeated or lost.
- STAGES=1, DESCENDING=1 (D=1), x0=k, x1=100+k, k=0..5 -> (0,1),(100,101),(2,3),(102,103). First out_valid 2 cycles after first accept.
- DESCENDING=0, STAGES=2 (delays 1 then 2), same stream as test 1 -> output equals a golden model of the stage composition in that order. Latency is still 5.
- Assert flush after k=5, then restart at k=0 -> stage_primed=00 the cycle after flush and out_valid low for the next 4 cycles. The output then matches test 1 from the start.
- reset asserted mid-stream at k=3 -> next cycle y0=y1=0, out_valid=0, stage_primed=0. Behaviour after release matches test 1.
